// File: rtl/seg7_display_arbiter_pkg.sv
// Shared types and constants for the seven-segment display arbiter slice.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        SHOW,
        RELEASE
    } state_t;

    localparam logic [31:0] IDLE_VALUE_DEFAULT = 32'h0000_0000;

    // Active-low segment pattern the driver emits when disp_blank is set.
    localparam logic [7:0] BLANK_SEG = 8'hFF;

endpackage

// File: rtl/seg7_display_arbiter_if.sv
// Requester/display bundle between the requesters (master) and the arbiter (slave).
interface seg7_display_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req;
    logic [32*NUM_REQ-1:0] req_value;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    done;
    logic [31:0]           disp_x;
    logic                  disp_blank;
    logic                  busy;

    modport master (
        output req, req_value,
        input  gnt, done, disp_x, disp_blank, busy
    );

    modport slave (
        input  req, req_value,
        output gnt, done, disp_x, disp_blank, busy
    );
endinterface

// File: rtl/seg7_display_arbiter_rr_pick.sv
// Round-robin first-set-bit search starting at rr_ptr, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int OW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OW-1:0]      rr_ptr,
    output logic [OW-1:0]      owner,
    output logic               valid
);
    logic [OW-1:0] idx;

    always_comb begin
        owner = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = OW'((32'(rr_ptr) + i) % 32'(NUM_REQ));
            if (!valid && req[idx]) begin
                valid = 1'b1;
                owner = idx;
            end
        end
    end
endmodule

// File: rtl/seg7_display_arbiter.sv
// Shares one 8-digit display among NUM_REQ requesters, round-robin, each grant
// held on screen for HOLD_TICKS prescaled ticks.
module seg7_display_arbiter
    import seg7_pkg::*;
#(
    parameter int          NUM_REQ    = 4,
    parameter int          TICK_DIV   = 100000,
    parameter int          HOLD_TICKS = 2000,
    parameter logic [31:0] IDLE_VALUE = IDLE_VALUE_DEFAULT
) (
    input logic                   clk,
    input logic                   rst_n,
    seg7_display_arbiter_if.slave bus
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t           state, state_nxt;
    logic [OW-1:0]    owner, rr_ptr, pick_owner;
    logic             pick_valid;
    logic [PW-1:0]    presc;
    logic [HW-1:0]    hold;
    logic [31:0]      latched;
    logic [NUM_REQ-1:0] owner_oh;
    logic             tick, own_req, expire;

    rr_pick #(.NUM_REQ(NUM_REQ), .OW(OW)) u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .owner  (pick_owner),
        .valid  (pick_valid)
    );

    assign own_req = bus.req[owner];
    assign tick    = (state == SHOW) && (presc == PW'(TICK_DIV - 1));
    assign expire  = (hold == '0);

    always_comb begin
        owner_oh        = '0;
        owner_oh[owner] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid) state_nxt = GRANT;
            GRANT:   state_nxt = SHOW;
            // Cancel wins over expiry; both leave without further ticks.
            SHOW:    if (!own_req || expire) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode from registered state so reset clears them asynchronously.
    assign bus.gnt        = (state == GRANT || state == SHOW) ? owner_oh : '0;
    assign bus.done       = (state == SHOW && own_req && expire) ? owner_oh : '0;
    assign bus.disp_x     = (state == SHOW) ? latched : IDLE_VALUE;
    assign bus.disp_blank = (state != SHOW);
    assign bus.busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= '0;
            rr_ptr  <= '0;
            presc   <= '0;
            hold    <= '0;
            latched <= IDLE_VALUE;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (pick_valid) owner <= pick_owner;
                    presc <= '0;
                end
                GRANT: begin
                    latched <= bus.req_value[{owner, 5'b0} +: 32];
                    hold    <= HW'(HOLD_TICKS);
                    presc   <= '0;
                end
                SHOW: begin
                    presc <= tick ? '0 : presc + 1'b1;
                    if (tick && !expire) hold <= hold - 1'b1;
                end
                RELEASE: begin
                    rr_ptr <= (owner == OW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                    presc  <= '0;
                end
                default: presc <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Directed self-checking bench for seg7_display_arbiter (NUM_REQ=4, TICK_DIV=10, HOLD_TICKS=3).
module tb_seg7_display_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    seg7_display_arbiter_if #(.NUM_REQ(4)) bus ();

    seg7_display_arbiter #(
        .NUM_REQ    (4),
        .TICK_DIV   (10),
        .HOLD_TICKS (3),
        .IDLE_VALUE (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_val(input int i, input logic [31:0] v);
        bus.req_value[32*i +: 32] = v;
    endtask

    logic [31:0] rr_vals [4];

    initial begin
        bus.req       = '0;
        bus.req_value = '0;
        rr_vals[0] = 32'hA000_0000;
        rr_vals[1] = 32'hA111_1111;
        rr_vals[2] = 32'hA222_2222;
        rr_vals[3] = 32'hA333_3333;

        // Reset state
        step(2);
        check("rst_gnt",   32'(bus.gnt), 32'h0);
        check("rst_done",  32'(bus.done), 32'h0);
        check("rst_dispx", bus.disp_x, 32'h0);
        check("rst_blank", 32'(bus.disp_blank), 32'h1);
        check("rst_busy",  32'(bus.busy), 32'h0);
        rst_n = 1'b1;
        step(3);
        check("idle_busy", 32'(bus.busy), 32'h0);

        // Single request on requester 1
        set_val(1, 32'h0000_1234);
        bus.req = 4'b0010;
        check("single_idle_gnt", 32'(bus.gnt), 32'h0);
        step(1);
        check("single_gnt_c1",   32'(bus.gnt), 32'h2);
        check("single_blank_c1", 32'(bus.disp_blank), 32'h1);
        step(1);
        check("single_dispx_c2", bus.disp_x, 32'h0000_1234);
        check("single_blank_c2", 32'(bus.disp_blank), 32'h0);
        step(29);
        check("single_done_early", 32'(bus.done), 32'h0);
        step(1);
        check("single_done_30", 32'(bus.done), 32'h2);
        step(1);
        bus.req = 4'b0000;
        check("single_rel_blank", 32'(bus.disp_blank), 32'h1);
        check("single_rel_gnt",   32'(bus.gnt), 32'h0);
        check("single_rel_dispx", bus.disp_x, 32'h0);
        check("single_rel_done",  32'(bus.done), 32'h0);
        step(2);
        check("single_back_idle", 32'(bus.busy), 32'h0);

        // Asynchronous reset mid-SHOW
        set_val(0, 32'h0000_00C3);
        bus.req = 4'b0001;
        step(2);
        check("mid_show_blank", 32'(bus.disp_blank), 32'h0);
        step(5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_gnt",   32'(bus.gnt), 32'h0);
        check("mid_rst_blank", 32'(bus.disp_blank), 32'h1);
        check("mid_rst_dispx", bus.disp_x, 32'h0);
        check("mid_rst_busy",  32'(bus.busy), 32'h0);
        check("mid_rst_done",  32'(bus.done), 32'h0);
        bus.req = 4'b0000;
        step(2);
        rst_n = 1'b1;
        step(3);
        check("post_rst_busy", 32'(bus.busy), 32'h0);

        // Round-robin with all requests held
        for (int i = 0; i < 4; i++) set_val(i, rr_vals[i]);
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step(1);
            check($sformatf("rr%0d_gnt", k), 32'(bus.gnt), 32'(4'b0001 << (k % 4)));
            step(1);
            check($sformatf("rr%0d_dispx", k), bus.disp_x, rr_vals[k % 4]);
            check($sformatf("rr%0d_blank", k), 32'(bus.disp_blank), 32'h0);
            step(30);
            check($sformatf("rr%0d_done", k), 32'(bus.done), 32'(4'b0001 << (k % 4)));
            step(1);
            check($sformatf("rr%0d_rel_blank", k), 32'(bus.disp_blank), 32'h1);
            check($sformatf("rr%0d_rel_gnt", k), 32'(bus.gnt), 32'h0);
            step(1);
            check($sformatf("rr%0d_idle_blank", k), 32'(bus.disp_blank), 32'h1);
        end
        bus.req = 4'b0000;
        step(2);

        // Cancel 5 cycles into SHOW; rr_ptr is now 1 so req 0 still wins alone
        bus.req = 4'b0001;
        step(1);
        check("cancel_gnt", 32'(bus.gnt), 32'h1);
        step(1);
        step(5);
        bus.req = 4'b0000;
        #1;
        check("cancel_no_done", 32'(bus.done), 32'h0);
        step(1);
        check("cancel_rel_busy",  32'(bus.busy), 32'h1);
        check("cancel_rel_blank", 32'(bus.disp_blank), 32'h1);
        check("cancel_rel_gnt",   32'(bus.gnt), 32'h0);
        check("cancel_rel_done",  32'(bus.done), 32'h0);
        // rr_ptr must be 1: with req 0 and 1 both set, requester 1 wins
        bus.req = 4'b0011;
        step(2);
        check("cancel_rrptr", 32'(bus.gnt), 32'h2);
        bus.req = 4'b0000;
        step(2);
        check("cancel2_rel_done", 32'(bus.done), 32'h0);
        step(1);

        // Value stability and collision: rr_ptr=2, owner 0
        set_val(0, 32'h5555_AAAA);
        set_val(2, 32'h0000_2222);
        bus.req = 4'b0001;
        step(2);
        check("stab_dispx0", bus.disp_x, 32'h5555_AAAA);
        set_val(0, 32'hDEAD_BEEF);
        bus.req = 4'b0101;
        step(10);
        check("stab_dispx_hold", bus.disp_x, 32'h5555_AAAA);
        check("stab_gnt_hold",   32'(bus.gnt), 32'h1);
        step(18);
        check("stab_done_early", 32'(bus.done), 32'h0);
        step(2);
        check("stab_done", 32'(bus.done), 32'h1);
        step(1);
        bus.req = 4'b0100;
        check("coll_rel_gnt", 32'(bus.gnt), 32'h0);
        step(2);
        check("coll_gnt2", 32'(bus.gnt), 32'h4);
        step(1);
        check("coll_dispx2", bus.disp_x, 32'h0000_2222);

        // Cancel on the expiry cycle
        step(29);
        check("exp_done_early", 32'(bus.done), 32'h0);
        step(1);
        bus.req = 4'b0000;
        #1;
        check("exp_cancel_done", 32'(bus.done), 32'h0);
        check("exp_cancel_gnt",  32'(bus.gnt), 32'h4);
        step(1);
        check("exp_rel_done",  32'(bus.done), 32'h0);
        check("exp_rel_blank", 32'(bus.disp_blank), 32'h1);
        check("exp_rel_busy",  32'(bus.busy), 32'h1);
        step(2);
        check("final_idle", 32'(bus.busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
